// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_ctrl
//  Brief    : MIPS multiply/divide controller. Owns HI/LO, models the fixed
//             multi-cycle latency of mult/multu/div/divu, and raises the
//             D-stage stall while a HI/LO-related instruction would collide
//             with an operation in flight.
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  md_op,
    input  logic [31:0] rs_E,
    input  logic [31:0] rt_E,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic        md_use_D,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall_md
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [5:0] c_MULT_CNT = 6'(MULT_CYCLES);
    localparam logic [5:0] c_DIV_CNT  = 6'(DIV_CYCLES);

    // The 6-bit down-counter bounds the usable latency range.
    if (MULT_CYCLES < 1 || MULT_CYCLES > 63) begin : g_chk_mult_cycles
        $error("muldiv_ctrl: MULT_CYCLES must be in 1..63");
    end
    if (DIV_CYCLES < 1 || DIV_CYCLES > 63) begin : g_chk_div_cycles
        $error("muldiv_ctrl: DIV_CYCLES must be in 1..63");
    end

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_commit;

    logic [5:0]  r_cnt;
    logic [31:0] r_res_hi;
    logic [31:0] r_res_lo;
    logic        r_div_zero;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    // ------------------------------------------------------------------------
    // Operation decode
    // ------------------------------------------------------------------------
    logic w_accept;
    logic w_is_div;
    logic w_is_signed;

    assign w_accept    = (r_state == S_IDLE) & start;
    assign w_is_div    = md_op[1];
    assign w_is_signed = ~md_op[0];

    // ------------------------------------------------------------------------
    // Multiplier: a 64x64 product truncated to 64 bits of the sign- or
    // zero-extended operands is the correct 64-bit result for both signed and
    // unsigned multiplication, so one multiplier serves mult and multu.
    // ------------------------------------------------------------------------
    logic [63:0] w_mul_a;
    logic [63:0] w_mul_b;
    logic [63:0] w_prod;

    assign w_mul_a = {{32{w_is_signed & rs_E[31]}}, rs_E};
    assign w_mul_b = {{32{w_is_signed & rt_E[31]}}, rt_E};
    assign w_prod  = w_mul_a * w_mul_b;

    // ------------------------------------------------------------------------
    // Divider: sign-magnitude around an unsigned core. The quotient is
    // negated when operand signs differ (truncation toward zero) and the
    // remainder takes the dividend's sign. 0x80000000 / -1 falls out
    // naturally: its magnitude 0x80000000 divided by 1, signs equal.
    // A zero divisor is replaced by 1 only to keep the core well defined;
    // the result is discarded by the div-by-zero flag.
    // ------------------------------------------------------------------------
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic        w_div_zero;
    logic [31:0] w_b_safe;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    assign w_a_neg    = w_is_signed & rs_E[31];
    assign w_b_neg    = w_is_signed & rt_E[31];
    assign w_a_mag    = w_a_neg ? (~rs_E + 32'd1) : rs_E;
    assign w_b_mag    = w_b_neg ? (~rt_E + 32'd1) : rt_E;
    assign w_div_zero = (rt_E == 32'd0);
    assign w_b_safe   = w_div_zero ? 32'd1 : w_b_mag;
    assign w_q_mag    = w_a_mag / w_b_safe;
    assign w_r_mag    = w_a_mag % w_b_safe;
    assign w_quot     = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_rem      = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and commit strobe: leave RUN on the edge where cnt reaches 1.
    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt <= 6'd1) begin
                    w_state_nxt = S_IDLE;
                    w_commit    = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------

    // Latch pending result, latency and div-by-zero flag on accept; count down in RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= 6'd0;
            r_res_hi   <= 32'd0;
            r_res_lo   <= 32'd0;
            r_div_zero <= 1'b0;
        end else if (w_accept) begin
            if (w_is_div) begin
                r_res_hi <= w_rem;
                r_res_lo <= w_quot;
                r_cnt    <= c_DIV_CNT;
            end else begin
                r_res_hi <= w_prod[63:32];
                r_res_lo <= w_prod[31:0];
                r_cnt    <= c_MULT_CNT;
            end
            r_div_zero <= w_is_div & w_div_zero;
        end else if (r_state == S_RUN) begin
            r_cnt <= r_cnt - 6'd1;
        end
    end

    // HI/LO: commit the pending result at the end of RUN, or take mthi/mtlo
    // in IDLE when no start competes for the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_commit) begin
            if (!r_div_zero) begin
                r_hi <= r_res_hi;
                r_lo <= r_res_lo;
            end
        end else if ((r_state == S_IDLE) && !start) begin
            if (mthi) begin
                r_hi <= rs_E;
            end
            if (mtlo) begin
                r_lo <= rs_E;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign busy     = (r_state == S_RUN);
    assign stall_md = md_use_D & (start | busy);

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_ctrl
//  Brief    : Self-checking bench for muldiv_ctrl. Expected HI/LO pairs are
//             queued when an operation starts and compared when busy drops.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  md_op;
    logic [31:0] rs_E;
    logic [31:0] rt_E;
    logic        mthi;
    logic        mtlo;
    logic        md_use_D;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall_md;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [63:0] exp_q[$];
    logic [63:0] m_hilo;          // bench-side shadow of {HI, LO}
    logic        expect_abort = 1'b0;
    logic        mon_prev_busy = 1'b0;

    muldiv_ctrl #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) u_dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .md_op   (md_op),
        .rs_E    (rs_E),
        .rt_E    (rt_E),
        .mthi    (mthi),
        .mtlo    (mtlo),
        .md_use_D(md_use_D),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .stall_md(stall_md)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point.
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference arithmetic in 64-bit integer terms; cur is returned for div-by-zero.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] cur);
        longint      sa;
        longint      sbv;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        case (op)
            2'b00: begin q = sa * sbv; return q; end
            2'b01: begin p = {32'd0, a} * {32'd0, b}; return p; end
            2'b10: begin
                if (b == 32'd0) return cur;
                q = sa / sbv;
                r = sa % sbv;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return cur;
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Scoreboard monitor: on each busy falling edge, compare HI/LO with the oldest entry.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (mon_prev_busy === 1'b1 && busy === 1'b0) begin
                if (expect_abort) begin
                    expect_abort = 1'b0;
                end else if (exp_q.size() == 0) begin
                    chk("sb_unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_hilo", {hi, lo}, e);
                end
            end
            mon_prev_busy = busy;
        end
    end

    // Issue one operation from posedge+1; optional: hold md_use_D, poke
    // start/mt while busy, or assert mthi/mtlo alongside start.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int n, input bit use_d, input bit poke, input bit with_mt);
        logic [63:0] e;
        int          busy_cnt;
        int          stall_cnt;
        e = model(op, a, b, m_hilo);
        exp_q.push_back(e);
        start    = 1'b1;
        md_op    = op;
        rs_E     = a;
        rt_E     = b;
        mthi     = with_mt;
        mtlo     = with_mt;
        md_use_D = use_d;
        #1;
        stall_cnt = (stall_md === 1'b1) ? 1 : 0;
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        busy_cnt = 0;
        while (busy === 1'b1 && busy_cnt < 200) begin
            busy_cnt++;
            if (stall_md === 1'b1) stall_cnt++;
            chk("no_bypass", {hi, lo}, m_hilo);
            if (poke && busy_cnt == 2) begin
                start = 1'b1; md_op = ~op; rs_E = ~a; rt_E = 32'd3;
                mthi = 1'b1; mtlo = 1'b1;
            end else begin
                start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        chk("busy_len", 64'(busy_cnt), 64'(n));
        if (use_d) begin
            chk("stall_len", 64'(stall_cnt), 64'(n + 1));
            chk("stall_off", {63'd0, stall_md}, 64'd0);
            chk("stall_lo_ready", {32'd0, lo}, {32'd0, e[31:0]});
            md_use_D = 1'b0;
        end
        m_hilo = e;
    endtask

    // mthi/mtlo from posedge+1; value visible one cycle later, busy untouched.
    task automatic do_mt(input bit h, input bit l, input logic [31:0] v);
        mthi = h; mtlo = l; rs_E = v;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0;
        if (h) m_hilo[63:32] = v;
        if (l) m_hilo[31:0]  = v;
        chk("mt_hilo", {hi, lo}, m_hilo);
        chk("mt_busy", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        reset = 1'b1; start = 1'b0; md_op = 2'b00; rs_E = 32'd0; rt_E = 32'd0;
        mthi = 1'b0; mtlo = 1'b0; md_use_D = 1'b0;
        m_hilo = 64'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_hilo", {hi, lo}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_stall", {63'd0, stall_md}, 64'd0);

        // mult -3 * 7 with mflo waiting in D
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 5, 1'b1, 1'b0, 1'b0);
        // multu, back to back with no dead cycle
        run_op(2'b01, 32'hFFFF_FFFF, 32'd2, 5, 1'b0, 1'b0, 1'b0);
        // div -7 / 2 with an ignored start/mt poke while busy, then divu 7 / 2
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 10, 1'b0, 1'b1, 1'b0);
        run_op(2'b11, 32'd7, 32'd2, 10, 1'b0, 1'b0, 1'b0);
        // signed overflow case
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b0, 1'b0, 1'b0);
        // divide by zero leaves mt values intact
        do_mt(1'b0, 1'b1, 32'h0000_1234);
        do_mt(1'b1, 1'b0, 32'h0000_5678);
        run_op(2'b10, 32'd99, 32'd0, 10, 1'b0, 1'b0, 1'b0);
        // start beats simultaneous mthi/mtlo
        run_op(2'b01, 32'h0001_0000, 32'h0001_0000, 5, 1'b0, 1'b0, 1'b1);
        // both mt writes in one cycle
        do_mt(1'b1, 1'b1, 32'hCAFE_F00D);

        // reset in the 3rd busy cycle of a div: abort, no late commit
        expect_abort = 1'b1;
        start = 1'b1; md_op = 2'b10; rs_E = 32'd100; rt_E = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_hilo = 64'd0;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        repeat (12) @(posedge clk);
        #1;
        chk("abort_no_late", {hi, lo}, 64'd0);
        chk("abort_still_idle", {63'd0, busy}, 64'd0);
        run_op(2'b00, 32'd12345, 32'hFFFF_FF00, 5, 1'b0, 1'b0, 1'b0);

        // a few random operations, one with a zero divisor
        for (int i = 0; i < 6; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i == 3) ? 32'd0 : $urandom;
            if (i == 3) rop = 2'b11;
            run_op(rop, ra, rb, rop[1] ? 10 : 5, 1'b0, 1'b0, 1'b0);
        end

        for (int k = 0; k < 5 && exp_q.size() != 0; k++) @(posedge clk);
        #1;
        chk("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multiply/divide unit controller for the five-stage MIPS pipeline. It accepts mult/multu/div/divu from the E stage and owns the HI/LO registers. It models the fixed multi-cycle latency of the multiplier and divider. It drives the D-stage stall when a later HI/LO-related instruction would collide with an operation still in flight.

## Interface

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- start  in  1  E-stage instruction is mult/multu/div/divu, valid this cycle
- md_op  in  2  operation with start: 00 mult, 01 multu, 10 div, 11 divu
- rs_E  in  32  forwarded rs operand (multiplicand / dividend)
- rt_E  in  32  forwarded rt operand (multiplier / divisor)
- mthi  in  1  E-stage mthi: write rs_E to HI
- mtlo  in  1  E-stage mtlo: write rs_E to LO
- md_use_D  in  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo (from decode mult_D/div_D/mfhi_D/mflo_D plus unsigned/mt variants)
- hi  out  32  HI register
- lo  out  32  LO register
- busy  out  1  operation in flight
- stall_md  out  1  freeze PC and IF/ID, bubble into ID/EX

## Operation

- States: IDLE, RUN. 6-bit down-counter cnt and 64-bit pending result {res_hi, res_lo}.
- IDLE + start:
  - latch the result of md_op on rs_E/rt_E into res_hi/res_lo;
  - cnt ← MULT_CYCLES or DIV_CYCLES;
  - latch a div-by-zero flag;
  - go RUN.
- RUN: cnt decrements each cycle. When cnt==1, commit res_hi→hi, res_lo→lo at that edge (skipped if the div-by-zero flag is set), then go IDLE.
- Arithmetic:
  - mult: signed 32×32→64.
  - multu: unsigned 32×32→64.
  - HI = upper word, LO = lower word.
  - div: signed, quotient truncated toward zero → LO; remainder carries the sign of the dividend → HI.
  - divu: unsigned.
  - Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divisor 0: HI/LO unchanged, full DIV_CYCLES busy still elapses.
- mthi/mtlo in IDLE: write rs_E to HI/LO at the edge. Both asserted: both written.
- Priority and ignore rules:
  - start together with mthi/mtlo: start wins, mt ignored.
  - start, mthi or mtlo while busy: ignored. The stall logic prevents this; the bench checks that it is ignored.
- stall_md = md_use_D & (start | busy). This is purely combinational; no stall is asserted for non-HI/LO instructions.
- Reset: hi=0, lo=0, busy=0, stall_md=0 (given md_use_D=0), state IDLE, cnt=0. Reset mid-operation aborts with no HI/LO commit.

## Timing

- start sampled in cycle t.
- busy=1 in cycles t+1 … t+N, where N = MULT_CYCLES or DIV_CYCLES.
- The new hi/lo values are visible from cycle t+N+1, together with busy=0.
- A new start is accepted in cycle t+N+1, with no dead cycle.
- mthi/mtlo sampled in cycle t: the value is visible on hi/lo in cycle t+1. busy is unaffected.
- mfhi/mflo reaching E in cycle t+N+1 reads the committed value. No bypass of the pending result onto hi/lo.
- stall_md holds for cycles t … t+N when md_use_D stays high, and deasserts in t+N+1.

## Test plan

- mult with rs_E=0xFFFFFFFD (-3), rt_E=7:
  - busy high for 5 cycles;
  - then hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- multu with 0xFFFFFFFF × 2 → hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
- div with -7 / 2:
  - busy high for 10 cycles;
  - lo=0xFFFFFFFD, hi=0xFFFFFFFF;
  - then divu with 7/2 → lo=3, hi=1.
- mflo in D (md_use_D=1) held from the start cycle:
  - stall_md=1 for exactly 6 cycles with mult;
  - 0 on the 7th, when lo holds the new value.
- Divide by zero (rt_E=0) after mtlo 0x1234 and mthi 0x5678:
  - 10 busy cycles;
  - hi=0x5678, lo=0x1234 unchanged.
- Reset in the 3rd busy cycle of div:
  - next cycle busy=0, hi=lo=0;
  - no late commit;
  - a fresh mult then completes normally.
